// File: rtl/rr_reg_arbiter.sv
// -----------------------------------------------------------------------------
// rr_reg_arbiter
//
// Round-robin controller sharing one W-bit register among N requesters. In
// IDLE the first active request at or after the priority pointer wins. The
// winner's data word is loaded into the shared register, a one-cycle grant
// pulse is issued, and a lockout of HOLD_CYC cycles follows before the next
// arbitration.
//
// Parameters:
//   N        number of requesters (2..8)
//   W        width of the shared register and of each data word
//   HOLD_CYC lockout cycles after each grant (0..15)
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-high reset
//   req      request per requester, bit i = requester i
//   wdata    packed data, requester i occupies [i*W +: W]
//   gnt      registered one-hot grant pulse, high for exactly one cycle
//   q        shared register contents
//   last_id  index of the most recently granted requester
//   busy     high whenever the controller is not in IDLE
// -----------------------------------------------------------------------------
module rr_reg_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned W        = 8,
    parameter int unsigned HOLD_CYC = 2,
    localparam int unsigned IW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] wdata,
    output logic [N-1:0]   gnt,
    output logic [W-1:0]   q,
    output logic [IW-1:0]  last_id,
    output logic           busy
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StGnt  = 2'd1;
    localparam logic [1:0] StHold = 2'd2;

    // Loaded on leaving GNT; HOLD exits on the edge where the counter is zero,
    // so HOLD lasts HOLD_CYC cycles.
    localparam logic [3:0] HoldInit = (HOLD_CYC > 0) ? (4'(HOLD_CYC) - 4'd1) : 4'd0;

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [W-1:0]  q_q, q_d;
    logic [IW-1:0] last_id_q, last_id_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          busy_q;

    logic          win_valid;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] ptr_next;
    logic [W-1:0]  win_data;
    logic [N-1:0]  win_onehot;
    int unsigned   probe;

    // Search req starting at ptr and wrapping modulo N; the first hit wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        probe     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            probe = (32'(ptr_q) + k) % N;
            if (!win_valid && req[probe[IW-1:0]]) begin
                win_valid = 1'b1;
                win_idx   = probe[IW-1:0];
            end
        end
    end

    // Winner's data word and one-hot grant vector.
    always_comb begin
        win_data   = '0;
        win_onehot = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (win_idx == IW'(i)) begin
                win_data      = wdata[i*W +: W];
                win_onehot[i] = 1'b1;
            end
        end
    end

    // The pointer moves just past the winner so it gets lowest priority next.
    assign ptr_next = (win_idx == IW'(N - 1)) ? '0 : (win_idx + 1'b1);

    always_comb begin
        state_d   = state_q;
        gnt_d     = '0;
        q_d       = q_q;
        last_id_d = last_id_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        case (state_q)
            StIdle: begin
                if (win_valid) begin
                    q_d       = win_data;
                    gnt_d     = win_onehot;
                    last_id_d = win_idx;
                    ptr_d     = ptr_next;
                    state_d   = StGnt;
                end
            end
            StGnt: begin
                if (HOLD_CYC > 0) begin
                    cnt_d   = HoldInit;
                    state_d = StHold;
                end else begin
                    state_d = StIdle;
                end
            end
            StHold: begin
                // Requests are ignored here; q keeps its value.
                if (cnt_q == 4'd0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            q_q       <= '0;
            last_id_q <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            q_q       <= q_d;
            last_id_q <= last_id_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            busy_q    <= (state_d != StIdle);
        end
    end

    assign gnt     = gnt_q;
    assign q       = q_q;
    assign last_id = last_id_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_reg_arbiter
//
// Directed bench for rr_reg_arbiter with N=4, W=8, HOLD_CYC=2. Inputs change
// 1 time unit after a rising edge; outputs are checked at the same point,
// i.e. after the edge that produced them.
// -----------------------------------------------------------------------------
module tb_rr_reg_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned IW = 2;

    logic           clk;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic [W-1:0]   q;
    logic [IW-1:0]  last_id;
    logic           busy;

    int n_cmp;
    int n_err;

    rr_reg_arbiter #(
        .N       (N),
        .W       (W),
        .HOLD_CYC(2)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .wdata  (wdata),
        .gnt    (gnt),
        .q      (q),
        .last_id(last_id),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int unsigned idx, input logic [7:0] val);
        wdata[idx*W +: W] = val;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] e_gnt, input logic [7:0] e_q,
                             input logic [1:0] e_id, input logic e_busy);
        check({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
        check({tag, ".q"}, 32'(q), 32'(e_q));
        check({tag, ".last_id"}, 32'(last_id), 32'(e_id));
        check({tag, ".busy"}, 32'(busy), 32'(e_busy));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        req   = 4'b1111;
        wdata = '0;
        for (int i = 0; i < 4; i++) set_data(i, 8'h10 + 8'(i));

        // Reset held for two cycles with all requests active.
        step();
        check_all("rst0", 4'b0000, 8'h00, 2'd0, 1'b0);
        step();
        check_all("rst1", 4'b0000, 8'h00, 2'd0, 1'b0);
        reset = 1'b0;

        // All requesters active: strict rotation, one grant every 4 cycles.
        for (int g = 0; g < 5; g++) begin
            step();
            check_all($sformatf("rot%0d.gnt", g), 4'(1 << (g % 4)), 8'h10 + 8'(g % 4),
                      2'(g % 4), 1'b1);
            step();
            check_all($sformatf("rot%0d.h1", g), 4'b0000, 8'h10 + 8'(g % 4), 2'(g % 4), 1'b1);
            step();
            check_all($sformatf("rot%0d.h2", g), 4'b0000, 8'h10 + 8'(g % 4), 2'(g % 4), 1'b1);
            step();
            check_all($sformatf("rot%0d.idle", g), 4'b0000, 8'h10 + 8'(g % 4), 2'(g % 4),
                      1'b0);
        end

        // Single request from requester 2 (pointer is at 1).
        req = 4'b0100;
        set_data(2, 8'hA5);
        step();
        check_all("single.gnt", 4'b0100, 8'hA5, 2'd2, 1'b1);
        req = 4'b0000;
        step();
        check_all("single.h1", 4'b0000, 8'hA5, 2'd2, 1'b1);
        step();
        check_all("single.h2", 4'b0000, 8'hA5, 2'd2, 1'b1);
        step();
        check_all("single.idle", 4'b0000, 8'hA5, 2'd2, 1'b0);
        step();
        check_all("single.idle2", 4'b0000, 8'hA5, 2'd2, 1'b0);

        // Pointer at 3, requests 3 and 0: 3 first, then wrap to 0.
        req = 4'b1001;
        set_data(3, 8'h33);
        set_data(0, 8'h30);
        step();
        check_all("wrap.g3", 4'b1000, 8'h33, 2'd3, 1'b1);
        req = 4'b0001;
        step();
        step();
        step();
        check_all("wrap.idle", 4'b0000, 8'h33, 2'd3, 1'b0);
        step();
        check_all("wrap.g0", 4'b0001, 8'h30, 2'd0, 1'b1);
        req = 4'b0000;
        step();
        step();
        step();

        // Requester 1 granted, then its data changes during HOLD and IDLE.
        req = 4'b0010;
        set_data(1, 8'h11);
        step();
        check_all("hold.g1", 4'b0010, 8'h11, 2'd1, 1'b1);
        req = 4'b0000;
        step();
        set_data(1, 8'hFF);
        step();
        check_all("hold.h2", 4'b0000, 8'h11, 2'd1, 1'b1);
        step();
        check_all("hold.idle", 4'b0000, 8'h11, 2'd1, 1'b0);
        step();
        check_all("hold.idle2", 4'b0000, 8'h11, 2'd1, 1'b0);
        req = 4'b0010;
        step();
        check_all("hold.g1ff", 4'b0010, 8'hFF, 2'd1, 1'b1);

        // Reset in the first HOLD cycle aborts the operation.
        req = 4'b0000;
        step();
        check_all("abort.h1", 4'b0000, 8'hFF, 2'd1, 1'b1);
        reset = 1'b1;
        step();
        check_all("abort.rst", 4'b0000, 8'h00, 2'd0, 1'b0);
        reset = 1'b0;
        req   = 4'b0010;
        set_data(1, 8'h5A);
        step();
        check_all("abort.g1", 4'b0010, 8'h5A, 2'd1, 1'b1);
        req = 4'b0000;
        step();
        step();
        step();
        // Pointer is now 2, so with all requests active requester 2 wins.
        req = 4'b1111;
        step();
        check_all("abort.g2", 4'b0100, 8'hA5, 2'd2, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
